// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives synchronous register-file reads, resolves operands
// with writeback bypass, and stalls issue on scoreboard (RAW/WAW) hazards.
//
// state   | meaning
// IDLE    | stage empty, may accept
// READ    | register-file read in flight for held instruction
// VALID   | resolved operands presented to execute
module operand_fetch #(
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic                 in_wr_rd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [4:0]           reg_rs1,
    output logic [4:0]           reg_rs2,
    input  logic [31:0]          reg_rd1,
    input  logic [31:0]          reg_rd2,
    input  logic                 wb_enable,
    input  logic [4:0]           wb_addr,
    input  logic [31:0]          wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_src1,
    output logic [31:0]          out_src2,
    output logic [4:0]           out_rd,
    output logic                 out_wr_rd,
    output logic [PAYLOAD_W-1:0] out_payload
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_VALID} state_t;

    state_t                 state, state_nxt;
    logic [31:0]            busy, busy_nxt, busy_eff, wb_hit;
    logic                   hazard, can_take, accept;
    logic [4:0]             lat_rs1, lat_rs2, lat_rd;
    logic                   lat_use1, lat_use2, lat_wr;
    logic [PAYLOAD_W-1:0]   lat_payload;
    logic                   byp1_flag, byp2_flag;
    logic [31:0]            byp1_data, byp2_data;
    logic [31:0]            op1, op2;

    function automatic logic [31:0] resolve(
        input logic        use_src,
        input logic [4:0]  idx,
        input logic        byp_flag,
        input logic [31:0] byp_data,
        input logic [31:0] rf_data,
        input logic        wb_en,
        input logic [4:0]  wb_idx,
        input logic [31:0] wb_val
    );
        if (!use_src || idx == 5'd0) return 32'd0;
        if (wb_en && wb_idx == idx) return wb_val;
        if (byp_flag) return byp_data;
        return rf_data;
    endfunction

    // A writeback landing this cycle already frees its register for issue.
    always_comb begin
        wb_hit   = wb_enable ? (32'd1 << wb_addr) : 32'd0;
        busy_eff = busy & ~wb_hit & ~32'd1;
        hazard   = (in_use_rs1 & busy_eff[in_rs1]) |
                   (in_use_rs2 & busy_eff[in_rs2]) |
                   (in_wr_rd   & busy_eff[in_rd]);
        can_take = (state == S_IDLE) | ((state == S_VALID) & out_ready);
        accept   = in_valid & in_ready;
        op1      = resolve(lat_use1, lat_rs1, byp1_flag, byp1_data, reg_rd1,
                           wb_enable, wb_addr, wb_data);
        op2      = resolve(lat_use2, lat_rs2, byp2_flag, byp2_data, reg_rd2,
                           wb_enable, wb_addr, wb_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_READ;
            S_READ:  state_nxt = flush ? S_IDLE : S_VALID;
            S_VALID: begin
                if (flush)          state_nxt = S_IDLE;
                else if (out_ready) state_nxt = accept ? S_READ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ~flush & ~hazard & can_take;
        out_valid = (state == S_VALID);
        reg_rs1   = can_take ? in_rs1 : lat_rs1;
        reg_rs2   = can_take ? in_rs2 : lat_rs2;
    end

    // Set beats clear: a new writer of a register retired this cycle stays busy.
    always_comb begin
        busy_nxt = busy & ~wb_hit;
        if (flush && state != S_IDLE && lat_wr) busy_nxt[lat_rd] = 1'b0;
        if (accept && in_wr_rd) busy_nxt[in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_rs1     <= '0;
            lat_rs2     <= '0;
            lat_rd      <= '0;
            lat_use1    <= 1'b0;
            lat_use2    <= 1'b0;
            lat_wr      <= 1'b0;
            lat_payload <= '0;
            byp1_flag   <= 1'b0;
            byp2_flag   <= 1'b0;
            byp1_data   <= '0;
            byp2_data   <= '0;
        end else if (accept) begin
            lat_rs1     <= in_rs1;
            lat_rs2     <= in_rs2;
            lat_rd      <= in_rd;
            lat_use1    <= in_use_rs1;
            lat_use2    <= in_use_rs2;
            lat_wr      <= in_wr_rd;
            lat_payload <= in_payload;
            byp1_flag   <= wb_enable && wb_addr != 5'd0 && wb_addr == in_rs1;
            byp2_flag   <= wb_enable && wb_addr != 5'd0 && wb_addr == in_rs2;
            byp1_data   <= wb_data;
            byp2_data   <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_src1    <= '0;
            out_src2    <= '0;
            out_rd      <= '0;
            out_wr_rd   <= 1'b0;
            out_payload <= '0;
        end else if (state == S_READ && !flush) begin
            out_src1    <= op1;
            out_src2    <= op2;
            out_rd      <= lat_rd;
            out_wr_rd   <= lat_wr;
            out_payload <= lat_payload;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic, checked against
// an architectural register/scoreboard model with a simple register-file stub.
module tb_operand_fetch;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [4:0]    in_rs1, in_rs2, in_rd;
    logic          in_use_rs1, in_use_rs2, in_wr_rd;
    logic [PW-1:0] in_payload;
    logic [4:0]    reg_rs1, reg_rs2;
    logic [31:0]   reg_rd1, reg_rd2;
    logic          wb_enable;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          flush;
    logic          out_valid, out_ready;
    logic [31:0]   out_src1, out_src2;
    logic [4:0]    out_rd;
    logic          out_wr_rd;
    logic [PW-1:0] out_payload;

    always #5 clk = ~clk;

    operand_fetch #(.PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
        .in_payload(in_payload),
        .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .reg_rd1(reg_rd1), .reg_rd2(reg_rd2),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd),
        .out_wr_rd(out_wr_rd), .out_payload(out_payload)
    );

    // Register-file stub: synchronous read returns the pre-write value.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            reg_rd1 <= '0;
            reg_rd2 <= '0;
        end else begin
            reg_rd1 <= mem[reg_rs1];
            reg_rd2 <= mem[reg_rs2];
            if (wb_enable && wb_addr != 5'd0) mem[wb_addr] <= wb_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model: architectural registers, pending writers, and the one held instruction.
    logic [31:0]   arch [32];
    bit   [31:0]   busy_m;
    int            exec_q[$];
    bit            held;
    int            age;
    logic [4:0]    h_rs1, h_rs2, h_rd;
    bit            h_u1, h_u2, h_w;
    logic [PW-1:0] h_pay;
    logic [31:0]   exp_s1, exp_s2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(input logic [4:0] i);
        return (i != 5'd0) && busy_m[i] && !(wb_enable && wb_addr == i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = '0;
        busy_m = '0;
        exec_q.delete();
        held = 1'b0;
        age  = 0;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wr_rd = 1'b0; in_payload = '0;
        wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input bit u1, input bit u2, input bit w, input logic [PW-1:0] p);
        in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rd = d;
        in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = w; in_payload = p;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_enable = 1'b1; wb_addr = a; wb_data = d;
    endtask

    // One clock: called at posedge+1 with inputs already driven, returns at posedge+1.
    task automatic tick();
        bit hz, exp_ov, exp_rdy, acc, hs;
        #1;
        hz = (in_use_rs1 && pend(in_rs1)) || (in_use_rs2 && pend(in_rs2)) ||
             (in_wr_rd && pend(in_rd));
        exp_ov  = held && age >= 1;
        exp_rdy = !flush && !hz && (!held || (exp_ov && out_ready));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            if (age == 1) begin
                exp_s1 = h_u1 ? arch[h_rs1] : 32'd0;
                exp_s2 = h_u2 ? arch[h_rs2] : 32'd0;
            end
            chk("out_src1", out_src1, exp_s1);
            chk("out_src2", out_src2, exp_s2);
            chk("out_rd", out_rd, h_rd);
            chk("out_wr_rd", out_wr_rd, h_w);
            chk("out_payload", out_payload, h_pay);
        end
        acc = in_valid && exp_rdy;
        hs  = exp_ov && out_ready && !flush;
        @(posedge clk);
        #1;
        if (wb_enable && wb_addr != 5'd0) begin
            arch[wb_addr]   = wb_data;
            busy_m[wb_addr] = 1'b0;
            for (int k = 0; k < exec_q.size(); k++)
                if (exec_q[k] == int'(wb_addr)) begin exec_q.delete(k); break; end
        end
        if (flush && held) begin
            if (h_w && h_rd != 5'd0) busy_m[h_rd] = 1'b0;
            held = 1'b0;
        end
        if (hs) begin
            if (h_w && h_rd != 5'd0) exec_q.push_back(int'(h_rd));
            held = 1'b0;
        end
        if (held) age++;
        if (acc) begin
            held = 1'b1; age = 0;
            h_rs1 = in_rs1; h_rs2 = in_rs2; h_rd = in_rd;
            h_u1 = in_use_rs1; h_u2 = in_use_rs2; h_w = in_wr_rd; h_pay = in_payload;
            if (in_wr_rd && in_rd != 5'd0) busy_m[in_rd] = 1'b1;
        end
    endtask

    initial begin
        logic [4:0] a;
        rst = 1'b1;
        idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_src1", out_src1, 32'd0);
        chk("rst_out_src2", out_src2, 32'd0);
        chk("rst_out_rd", out_rd, 5'd0);
        chk("rst_out_wr_rd", out_wr_rd, 1'b0);
        chk("rst_out_payload", out_payload, '0);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            wb(5'(i), (i == 5) ? 32'h11 : (i == 6) ? 32'h22 : $urandom);
            tick();
        end
        idle_in();

        // Plain read of x5/x6.
        issue(5, 6, 0, 1, 1, 0, 32'hA5A5_0001);
        tick();
        idle_in();
        tick();
        chk("t1_src1", out_src1, 32'h11);
        chk("t1_src2", out_src2, 32'h22);
        chk("t1_payload", out_payload, 32'hA5A5_0001);
        tick();

        // Writeback on the accept edge, then during READ.
        issue(7, 0, 0, 1, 0, 0, 32'h2);
        wb(7, 32'hDEAD);
        tick();
        idle_in();
        tick();
        chk("t2_same_edge", out_src1, 32'hDEAD);
        tick();
        wb(7, 32'h1234);
        tick();
        idle_in();
        issue(7, 0, 0, 1, 0, 0, 32'h3);
        tick();
        idle_in();
        wb(7, 32'hDEAD);
        tick();
        idle_in();
        chk("t2_read_cycle", out_src1, 32'hDEAD);
        tick();

        // RAW stall until x3 writeback, then WAW stall.
        issue(0, 0, 3, 0, 0, 1, 32'h4);
        tick();
        idle_in();
        tick();
        tick();
        issue(3, 0, 0, 1, 0, 0, 32'h5);
        for (int k = 0; k < 2; k++) begin
            #1 chk("t3_raw_stall", in_ready, 1'b0);
            tick();
        end
        wb(3, 32'h55);
        #1 chk("t3_raw_release", in_ready, 1'b1);
        tick();
        idle_in();
        tick();
        chk("t3_src1", out_src1, 32'h55);
        tick();
        issue(0, 0, 3, 0, 0, 1, 32'h6);
        tick();
        idle_in();
        tick();
        tick();
        issue(0, 0, 3, 0, 0, 1, 32'h7);
        #1 chk("t3_waw_stall", in_ready, 1'b0);
        tick();
        wb(3, 32'h66);
        #1 chk("t3_waw_release", in_ready, 1'b1);
        tick();
        idle_in();
        tick();
        tick();
        wb(3, 32'h77);
        tick();
        idle_in();

        // x0: writeback ignored, rd=0 never marks busy.
        issue(0, 0, 0, 1, 0, 1, 32'h8);
        wb(0, 32'hFFFF_FFFF);
        tick();
        idle_in();
        tick();
        chk("t4_x0_src1", out_src1, 32'd0);
        tick();
        issue(0, 0, 0, 1, 1, 0, 32'h9);
        #1 chk("t4_x0_not_busy", in_ready, 1'b1);
        tick();
        idle_in();
        tick();
        tick();

        // Backpressure for 3 cycles, then handshake plus accept on one edge.
        issue(5, 6, 1, 1, 1, 0, 32'hA);
        tick();
        idle_in();
        out_ready = 1'b0;
        tick();
        issue(6, 5, 2, 1, 1, 0, 32'hB);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t5_held_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        idle_in();
        chk("t5_gap", out_valid, 1'b0);
        tick();
        chk("t5_next_valid", out_valid, 1'b1);
        chk("t5_next_src1", out_src1, 32'h22);
        tick();

        // Flush in READ of a writer to x9.
        issue(0, 0, 9, 0, 0, 1, 32'hC);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("t6_flush_valid", out_valid, 1'b0);
        issue(9, 0, 0, 1, 0, 0, 32'hD);
        #1 chk("t6_x9_free", in_ready, 1'b1);
        tick();
        idle_in();
        tick();
        tick();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 7));
            in_use_rs1 = 1'($urandom_range(0, 1));
            in_use_rs2 = 1'($urandom_range(0, 1));
            in_wr_rd   = 1'($urandom_range(0, 1));
            in_payload = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            wb_enable  = 1'b0;
            wb_addr    = '0;
            wb_data    = $urandom;
            if (exec_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb(5'(exec_q[0]), $urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                a = 5'($urandom_range(0, 7));
                if (!busy_m[a]) wb(a, $urandom);
            end
            tick();
        end
        idle_in();
        tick();

        // Asynchronous reset in the middle of READ.
        issue(5, 6, 4, 1, 1, 1, 32'hE);
        tick();
        idle_in();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_src1", out_src1, 32'd0);
        chk("t6_rst_src2", out_src2, 32'd0);
        chk("t6_rst_rd", out_rd, 5'd0);
        chk("t6_rst_wr_rd", out_wr_rd, 1'b0);
        chk("t6_rst_payload", out_payload, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        issue(0, 0, 4, 0, 0, 1, 32'hF);
        #1 chk("t6_rst_idle_ready", in_ready, 1'b1);
        tick();
        idle_in();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
